// File: rtl/drive_sequencer_if.sv
// drive_sequencer_if
//
// Purpose: bundles the command/status signals of the drive sequencer so a
// controller and the sequencer can be wired with a single port.
//
// Signals:
//   start        controller -> sequencer  request to run a plan
//   abort        controller -> sequencer  stop the current plan immediately
//   dist0..dist2 controller -> sequencer  hold lengths (ticks) for legs 0..2
//   dir          sequencer -> controller  00 stop, 01 forward, 10 reverse
//   busy         sequencer -> controller  high while a plan is executing
//   done         sequencer -> controller  one-cycle pulse on normal completion
//   leg          sequencer -> controller  current leg index (0..2)
//
// Modports: master = the controller side, slave = the sequencer side.

interface drive_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] dist0;
  logic [7:0] dist1;
  logic [7:0] dist2;
  logic [1:0] dir;
  logic       busy;
  logic       done;
  logic [1:0] leg;

  modport master (
    output start, abort, dist0, dist1, dist2,
    input  dir, busy, done, leg
  );

  modport slave (
    input  start, abort, dist0, dist1, dist2,
    output dir, busy, done, leg
  );
endinterface

// File: rtl/drive_sequencer.sv
// drive_sequencer
//
// Purpose: runs a three-leg motion plan. Each leg is an optional stationary
// hold (length taken from dist0..dist2, skipped when zero) followed by a
// forward run of MOVE_TICKS ticks; after leg 2 the drive reverses for
// RETURN_TICKS ticks and the block returns to IDLE with a done pulse.
// One tick is TICK_DIV clk cycles.
//
// Ports:
//   clk  clock for all logic
//   rst  asynchronous, active-high reset
//   bus  drive_sequencer_if.slave (start/abort/dist0..2 in; dir/busy/done/leg out)
//
// Parameters:
//   TICK_DIV      clk cycles per tick (1 .. 2^30-1)
//   MOVE_TICKS    ticks per forward segment (1..255)
//   RETURN_TICKS  ticks for the final reverse segment (1..255)

module drive_sequencer #(
  parameter int TICK_DIV     = 2_000_000,
  parameter int MOVE_TICKS   = 4,
  parameter int RETURN_TICKS = 8
) (
  input logic              clk,
  input logic              rst,
  drive_sequencer_if.slave bus
);

  localparam logic [29:0] PRESC_MAX = 30'(TICK_DIV - 1);
  localparam logic [7:0]  MOVE_LEN  = 8'(MOVE_TICKS);
  localparam logic [7:0]  RET_LEN   = 8'(RETURN_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    RET  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [29:0] presc;
  logic [7:0]  seg_cnt;
  logic [7:0]  dist_q0, dist_q1, dist_q2;
  logic [1:0]  leg_q, leg_d;
  logic [1:0]  dir_q, dir_d;
  logic        busy_q, done_q;

  logic [7:0]  hold_len, next_dist, seg_len;
  logic        tick, seg_end, accept, finish;

  assign bus.dir  = dir_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.leg  = leg_q;

  // Next-state logic. Abort outranks everything, including a segment that
  // happens to end on the same edge. A zero-length hold is never entered:
  // the decision to skip it is made when the preceding segment ends (or at
  // accept time for leg 0, using the live dist0 being latched that edge).
  always_comb begin
    state_d   = state;
    leg_d     = leg_q;
    accept    = 1'b0;
    finish    = 1'b0;
    dir_d     = 2'b00;
    tick      = (presc == PRESC_MAX);

    case (leg_q)
      2'd0:    hold_len = dist_q0;
      2'd1:    hold_len = dist_q1;
      default: hold_len = dist_q2;
    endcase

    // Hold length of the leg that follows the current run segment.
    next_dist = (leg_q == 2'd0) ? dist_q1 : dist_q2;

    case (state)
      HOLD:    seg_len = hold_len;
      RET:     seg_len = RET_LEN;
      default: seg_len = MOVE_LEN;
    endcase

    seg_end = tick && (seg_cnt == seg_len - 8'd1);

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          leg_d   = 2'd0;
          state_d = (bus.dist0 == 8'd0) ? RUN : HOLD;
        end
      end
      default: begin
        if (bus.abort) begin
          state_d = IDLE;
          leg_d   = 2'd0;
        end else if (seg_end) begin
          case (state)
            HOLD: state_d = RUN;
            RUN: begin
              if (leg_q == 2'd2) begin
                state_d = RET;
                leg_d   = 2'd0;
              end else begin
                leg_d   = leg_q + 2'd1;
                state_d = (next_dist == 8'd0) ? RUN : HOLD;
              end
            end
            default: begin
              state_d = IDLE;
              finish  = 1'b1;
            end
          endcase
        end
      end
    endcase

    case (state_d)
      RUN:     dir_d = 2'b01;
      RET:     dir_d = 2'b10;
      default: dir_d = 2'b00;
    endcase
  end

  // Registered state and outputs. dir/busy are derived from the next state so
  // they change on the same edge as the state itself. Prescaler and segment
  // counter sit at zero whenever the block is (or is about to be) idle, so an
  // abort leaves them clean for the next plan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      seg_cnt <= '0;
      dist_q0 <= '0;
      dist_q1 <= '0;
      dist_q2 <= '0;
      leg_q   <= '0;
      dir_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_d;
      leg_q  <= leg_d;
      dir_q  <= dir_d;
      busy_q <= (state_d != IDLE);
      done_q <= finish;

      if (accept) begin
        dist_q0 <= bus.dist0;
        dist_q1 <= bus.dist1;
        dist_q2 <= bus.dist2;
        presc   <= '0;
        seg_cnt <= '0;
      end else if (state_d == IDLE) begin
        presc   <= '0;
        seg_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 30'd1;
        if (seg_end) begin
          seg_cnt <= '0;
        end else if (tick) begin
          seg_cnt <= seg_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer
//
// Purpose: self-checking bench for drive_sequencer with TICK_DIV=4,
// MOVE_TICKS=3, RETURN_TICKS=6. The expected per-cycle dir/leg trace of a
// plan is built from the plan's list of segments (hold, run per leg, then
// the reverse), and compared against the DUT cycle by cycle.

module tb_drive_sequencer;

  localparam int TD = 4;
  localparam int MT = 3;
  localparam int RT = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [1:0] exp_dir[$];
  logic [1:0] exp_leg[$];

  drive_sequencer_if bus ();

  drive_sequencer #(
    .TICK_DIV    (TD),
    .MOVE_TICKS  (MT),
    .RETURN_TICKS(RT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock; posedges at 5, 15, ... so negedges fall mid-cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic a,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2);
    bus.start = s;
    bus.abort = a;
    bus.dist0 = d0;
    bus.dist1 = d1;
    bus.dist2 = d2;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] dir_e,
                             input logic busy_e, input logic done_e,
                             input logic [1:0] leg_e);
    total++;
    assert (bus.dir === dir_e) else begin
      bad++;
      $error("[TB] FAIL %s dir: got %b want %b", tag, bus.dir, dir_e);
    end
    total++;
    assert (bus.busy === busy_e) else begin
      bad++;
      $error("[TB] FAIL %s busy: got %b want %b", tag, bus.busy, busy_e);
    end
    total++;
    assert (bus.done === done_e) else begin
      bad++;
      $error("[TB] FAIL %s done: got %b want %b", tag, bus.done, done_e);
    end
    total++;
    assert (bus.leg === leg_e) else begin
      bad++;
      $error("[TB] FAIL %s leg: got %0d want %0d", tag, bus.leg, leg_e);
    end
  endtask

  // Expected trace: per leg an optional hold of dist*TD cycles then a run of
  // MT*TD cycles, followed by RT*TD cycles of reverse with leg reported as 0.
  task automatic build_plan(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2);
    int d[3];
    d[0] = int'(d0);
    d[1] = int'(d1);
    d[2] = int'(d2);
    exp_dir.delete();
    exp_leg.delete();
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < d[l] * TD; c++) begin
        exp_dir.push_back(2'b00);
        exp_leg.push_back(2'(l));
      end
      for (int c = 0; c < MT * TD; c++) begin
        exp_dir.push_back(2'b01);
        exp_leg.push_back(2'(l));
      end
    end
    for (int c = 0; c < RT * TD; c++) begin
      exp_dir.push_back(2'b10);
      exp_leg.push_back(2'b00);
    end
  endtask

  // Called at the first negedge after the accept edge. Walks the whole plan,
  // then checks the done cycle and returns at the following negedge.
  // With perturb set, a stray start pulse and new dist values are applied
  // mid-plan; neither may alter the trace.
  task automatic check_plan(input string name, input logic [7:0] d0,
                            input logic [7:0] d1, input logic [7:0] d2,
                            input bit perturb);
    int n;
    build_plan(d0, d1, d2);
    n = exp_dir.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s c%0d", name, i), exp_dir[i], 1'b1, 1'b0, exp_leg[i]);
      if (perturb) begin
        if (i == 5) bus.start = 1'b1;
        if (i == 6) bus.start = 1'b0;
        if (i == 20) begin
          bus.dist0 = 8'($urandom_range(0, 9));
          bus.dist1 = 8'($urandom_range(0, 9));
          bus.dist2 = 8'($urandom_range(0, 9));
        end
      end
      @(negedge clk);
    end
    checkOutput($sformatf("%s done", name), 2'b00, 1'b0, 1'b1, 2'b00);
    @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2);
    applyStimulus(1'b1, 1'b0, d0, d1, d2);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] r0, r1, r2;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);

    // Reset state.
    @(negedge clk);
    checkOutput("reset", 2'b00, 1'b0, 1'b0, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle after reset", 2'b00, 1'b0, 1'b0, 2'b00);

    // Directed plan (2,0,1).
    $display("[TB] plan 2,0,1");
    launch(8'd2, 8'd0, 8'd1);
    check_plan("p201", 8'd2, 8'd0, 8'd1, 1'b0);
    checkOutput("p201 after done", 2'b00, 1'b0, 1'b0, 2'b00);

    // All holds skipped.
    $display("[TB] plan 0,0,0");
    launch(8'd0, 8'd0, 8'd0);
    check_plan("p000", 8'd0, 8'd0, 8'd0, 1'b0);

    // Same plan with a stray start and dist changes mid-plan.
    $display("[TB] plan 2,0,1 perturbed");
    launch(8'd2, 8'd0, 8'd1);
    check_plan("p201x", 8'd2, 8'd0, 8'd1, 1'b1);

    // abort and start together in IDLE: abort wins.
    applyStimulus(1'b1, 1'b1, 8'd1, 8'd1, 8'd1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 8'd1, 8'd1, 8'd1);
    checkOutput("abort+start idle", 2'b00, 1'b0, 1'b0, 2'b00);

    // Randomized plans.
    for (int k = 0; k < 4; k++) begin
      r0 = 8'($urandom_range(0, 3));
      r1 = 8'($urandom_range(0, 3));
      r2 = 8'($urandom_range(0, 3));
      $display("[TB] random plan %0d,%0d,%0d", r0, r1, r2);
      launch(r0, r1, r2);
      check_plan($sformatf("rnd%0d", k), r0, r1, r2, 1'b0);
    end

    // Abort 10 cycles into leg-0 run.
    $display("[TB] abort test");
    launch(8'd0, 8'd5, 8'd5);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("abort run c%0d", i), 2'b01, 1'b1, 1'b0, 2'b00);
      if (i == 9) bus.abort = 1'b1;
      @(negedge clk);
    end
    checkOutput("after abort", 2'b00, 1'b0, 1'b0, 2'b00);
    bus.abort = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post abort c%0d", i), 2'b00, 1'b0, 1'b0, 2'b00);
    end
    launch(8'd1, 8'd2, 8'd0);
    check_plan("after abort plan", 8'd1, 8'd2, 8'd0, 1'b0);

    // Asynchronous reset during the reverse segment.
    $display("[TB] async reset in RET");
    launch(8'd0, 8'd0, 8'd0);
    build_plan(8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      checkOutput($sformatf("pre-rst c%0d", i), exp_dir[i], 1'b1, 1'b0, exp_leg[i]);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("async rst", 2'b00, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("post rst c%0d", i), 2'b00, 1'b0, 1'b0, 2'b00);
    end

    // start held high: next plan begins straight after the done cycle.
    $display("[TB] start held");
    applyStimulus(1'b1, 1'b0, 8'd1, 8'd0, 8'd0);
    @(negedge clk);
    check_plan("held1", 8'd1, 8'd0, 8'd0, 1'b0);
    bus.start = 1'b0;
    check_plan("held2", 8'd1, 8'd0, 8'd0, 1'b0);
    checkOutput("held end", 2'b00, 1'b0, 1'b0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter: TICK_DIV, default 2_000_000, clk cycles per sequencing tick; legal range 1 to 2^30-1.
REQ-002 Parameter: MOVE_TICKS, default 4, ticks per forward-run segment; legal range 1..255.
REQ-003 Parameter: RETURN_TICKS, default 8, ticks for the final reverse segment; legal range 1..255.
REQ-004 Port: clk  input  1  single clock for all logic.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: start  input  1  request to run a plan; sampled on rising clk edges.
REQ-007 Port: abort  input  1  stop the current plan immediately.
REQ-008 Port: dist0, dist1, dist2  input  8 each  hold lengths in ticks for legs 0, 1 and 2.
REQ-009 Port: dir  output  2  motor-driver command: 00 = stop, 01 = forward, 10 = reverse, 11 never driven.
REQ-010 Port: busy  output  1  high while a plan is executing.
REQ-011 Port: done  output  1  one-cycle pulse on normal plan completion.
REQ-012 Port: leg  output  2  index of the current leg (0..2); 0 in IDLE and RET.

Function
REQ-013 States SHALL be IDLE, HOLD, RUN and RET.
REQ-014 dir SHALL be registered and encode the state: IDLE/HOLD -> 00, RUN -> 01, RET -> 10.
REQ-015 busy SHALL be registered and high exactly when the state is not IDLE.
REQ-016 start SHALL be accepted only in IDLE with abort low; start in any other state SHALL be ignored.
REQ-017 On acceptance, the block SHALL latch dist0..dist2 in the same edge, with these effects:
  - prescaler cleared to 0;
  - segment counter cleared to 0;
  - leg set to 0;
  - next state is HOLD, or RUN if the latched dist0 = 0.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and wrap; tick = 1 when prescaler = TICK_DIV-1; it SHALL be held at 0 in IDLE.
REQ-019 The segment counter SHALL advance on each tick. When it equals the segment length minus 1 on a tick, it SHALL clear and the state SHALL transition.
REQ-020 Segment lengths SHALL be: HOLD = latched dist of the current leg, RUN = MOVE_TICKS, RET = RETURN_TICKS.
REQ-021 Each segment SHALL therefore last exactly length*TICK_DIV clk cycles.
REQ-022 Transitions at segment end:
  - HOLD(i) -> RUN(i);
  - RUN(i), i<2 -> HOLD(i+1), or RUN(i+1) if dist(i+1) = 0;
  - RUN(2) -> RET;
  - RET -> IDLE.
REQ-023 done SHALL pulse for exactly one cycle, coincident with the first IDLE cycle after RET ends.
REQ-024 abort = 1 in any non-IDLE state SHALL force IDLE, dir = 00, busy = 0 and leg = 0 on the next edge, with no done pulse.
REQ-025 abort and start high together in IDLE: abort SHALL win and start SHALL be ignored.
REQ-026 Changes on dist0..dist2 while busy SHALL have no effect on the running plan.
REQ-027 A start that is high in the same cycle done is high SHALL be accepted, since the state is IDLE.

Reset
REQ-028 While rst is high:
  - state = IDLE, prescaler = 0, segment counter = 0, latched distances = 0;
  - dir = 00, busy = 0, done = 0, leg = 0.
REQ-029 Asserting rst mid-plan SHALL drop dir to 00 asynchronously, without waiting for a clock edge.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until a start is accepted.

Verification (TICK_DIV=4, MOVE_TICKS=3, RETURN_TICKS=6)
REQ-031 Plan with dists (2, 0, 1), start pulsed in IDLE. Required sequence after the accept edge:
  - dir = 00 for 8 cycles;
  - dir = 01 for 12 cycles (leg 0);
  - dir = 01 for 12 cycles (leg 1);
  - dir = 00 for 4 cycles;
  - dir = 01 for 12 cycles (leg 2);
  - dir = 10 for 24 cycles;
  - then done = 1 for one cycle, with busy high for all 72 cycles.
REQ-032 Plan with dists (0, 0, 0): dir = 01 for 36 cycles, then 10 for 24 cycles, then done.
REQ-033 abort 10 cycles into leg-0 RUN -> dir = 00 and busy = 0 on the next edge; no done; a later start is accepted normally.
REQ-034 start pulsed while busy, and dist0..dist2 changed mid-plan -> the timing trace is identical to REQ-031.
REQ-035 rst asserted asynchronously mid-RET -> dir = 00 immediately; after release, all outputs stay at reset values until the next start.
REQ-036 start held high continuously -> a new plan begins on the cycle done pulses, back-to-back with no gap.
